// File: rtl/cla4_nibble_seq_adder.sv
// ============================================================================
// Module   : cla4_nibble_seq_adder
// Purpose  : Multi-cycle adder that drives an external 4-bit CLA slice once
//            per nibble, LSB first, and chains the carry between passes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla4_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_ci,
  input  logic [3:0]       cla_sum,
  input  logic             cla_co,
  input  logic             cla_cp
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cla_a   = 4'd0;
    cla_b   = 4'd0;
    cla_ci  = 1'b0;

    if (state_q == ST_RUN) begin
      cla_a  = a_q[4*idx_q +: 4];
      cla_b  = b_q[4*idx_q +: 4];
      cla_ci = carry_q;
    end

    // Flush only rewinds control; the visible result registers stay untouched.
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            idx_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          sum_d[4*idx_q +: 4] = cla_sum;
          carry_d = cla_co;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_d  = cla_co;
            ovf_d   = cla_co ^ cla_cp;
            idx_d   = '0;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_cla4_nibble_seq_adder.sv
// ============================================================================
// Module   : tb_cla4_nibble_seq_adder
// Purpose  : Scoreboard bench for the nibble-serial adder with a CLA4 model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla4_nibble_seq_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;
  logic [3:0]       cla_a;
  logic [3:0]       cla_b;
  logic             cla_ci;
  logic [3:0]       cla_sum;
  logic             cla_co;
  logic             cla_cp;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t sb[$];

  // External CLA slice model
  logic [4:0] cla_full;
  logic [3:0] cla_low3;
  assign cla_full = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_ci};
  assign cla_low3 = {1'b0, cla_a[2:0]} + {1'b0, cla_b[2:0]} + {3'd0, cla_ci};
  assign cla_sum  = cla_full[3:0];
  assign cla_co   = cla_full[4];
  assign cla_cp   = cla_low3[3];

  cla4_nibble_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf),
    .busy     (busy),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_ci   (cla_ci),
    .cla_sum  (cla_sum),
    .cla_co   (cla_co),
    .cla_cp   (cla_cp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    res_t r;
    int unsigned us;
    int ss;
    us = int'(a) + int'(b) + int'(cin);
    ss = int'($signed(a)) + int'($signed(b)) + int'(cin);
    r.sum  = us[WIDTH-1:0];
    r.cout = (us >= (1 << WIDTH));
    r.ovf  = (ss > (1 << (WIDTH-1)) - 1) || (ss < -(1 << (WIDTH-1)));
    return r;
  endfunction

  // Monitor: compares each delivered result with the oldest expected entry
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("out_sum",  32'(out_sum),  32'(e.sum));
        chk("out_cout", 32'(out_cout), 32'(e.cout));
        chk("out_ovf",  32'(out_ovf),  32'(e.ovf));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("timeout_in_ready", 32'd0, 32'd1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
  endtask

  // Presents one operand pair; returns #1 after the accepting edge
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    wait_ready();
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    sb.push_back(model(a, b, cin));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    logic [WIDTH-1:0] ra, rb;

    // Reset state
    #3;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Carry ripple through every nibble, latency of exactly NIBBLES edges
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("lat_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("lat_out_valid", 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    wait_ready();

    send(16'h7FFF, 16'h0001, 1'b0);
    wait_ready();
    send(16'h8000, 16'h8000, 1'b0);
    wait_ready();

    // cla_ci sequence per RUN cycle
    send(16'h1234, 16'h4321, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("run_cla_ci", 32'(cla_ci), (k == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("done_cla_a", 32'(cla_a), 32'd0);
    wait_ready();

    // Backpressure
    out_ready = 1'b0;
    send(16'hA5A5, 16'h5A5B, 1'b0);
    e = model(16'hA5A5, 16'h5A5B, 1'b0);
    wait_out_valid();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_sum",   32'(out_sum),   32'(e.sum));
      chk("bp_out_cout",  32'(out_cout),  32'(e.cout));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  32'(in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Flush on the second RUN cycle drops the operation
    send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    void'(sb.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy",     32'(busy),     32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("flush_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    send(16'h0F0F, 16'h00F1, 1'b0);
    wait_ready();

    // Async reset mid-RUN
    send(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sum",   32'(out_sum),   32'd0);
    chk("arst_out_cout",  32'(out_cout),  32'd0);
    chk("arst_out_ovf",   32'(out_ovf),   32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_cla_ci",    32'(cla_ci),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_ready();

    // Randomized adds with random backpressure
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 8 == 0) ra = 16'h8000;
      if (n % 8 == 1) rb = 16'h7FFF;
      send(ra, rb, 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        out_ready = 1'b0;
        wait_out_valid();
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      wait_ready();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
